onchip_frame_reader: RTL and testbench

//  Avalon-MM read master feeding Avalon-ST: on a start pulse, reads LEN consecutive 32-bit words

---
 rtl/onchip_frame_reader.sv | 172 +++++++++++++++++
 tb/tb_onchip_frame_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_frame_reader.sv
// onchip_frame_reader: Avalon-MM read master that streams LEN words from on-chip
// RAM (read latency 1) as a single Avalon-ST packet through a small output FIFO.
module onchip_frame_reader #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 18,
  parameter int MEM_WORDS  = 163840,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_sop,
  output logic              src_eop
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_e;

  state_e              state_q;
  logic                busy_q;
  logic                done_q;
  logic                cs_q;
  logic                rvalid_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   next_q;
  logic [LEN_W-1:0]    remain_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q;

  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;

  logic                fifo_empty;
  logic                beat_fire;
  logic                last_beat;
  logic                push;
  logic                pop;
  logic [CNT_W:0]      used;
  logic                credit_ok;

  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction

  assign busy           = busy_q;
  assign done           = done_q;
  assign mem_address    = addr_q;
  assign mem_chipselect = cs_q;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;

  // Stream head: when the FIFO is empty the word returning from RAM is offered
  // directly, so first data appears the cycle after chipselect; if it is not
  // taken it is pushed and re-offered unchanged from the FIFO head.
  always_comb begin
    fifo_empty = (count_q == '0);
    src_valid  = !fifo_empty || rvalid_q;
    src_data   = fifo_empty ? mem_readdata : fifo_mem_q[rd_ptr_q];
    beat_fire  = src_valid && src_ready;
    last_beat  = (beat_q == (len_q - LEN_W'(1)));
    src_sop    = src_valid && (beat_q == '0);
    src_eop    = src_valid && last_beat;
    pop        = beat_fire && !fifo_empty;
    push       = rvalid_q && !(beat_fire && fifo_empty);
    // Words issued but not yet delivered: queued + returning + being issued.
    used       = (CNT_W+1)'(count_q) + (CNT_W+1)'(rvalid_q) + (CNT_W+1)'(cs_q);
    credit_ok  = (used < (CNT_W+1)'(FIFO_DEPTH));
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= mem_readdata;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Transfer FSM with read issue, beat counting and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      next_q   <= '0;
      remain_q <= '0;
      len_q    <= '0;
      beat_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      cs_q     <= 1'b0;
      rvalid_q <= cs_q;
      if (beat_fire) begin
        beat_q <= last_beat ? '0 : beat_q + LEN_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              // First read is issued on the accepting edge; FIFO is empty here.
              busy_q   <= 1'b1;
              cs_q     <= 1'b1;
              addr_q   <= base_addr;
              next_q   <= wrap_inc(base_addr);
              remain_q <= length - LEN_W'(1);
              len_q    <= length;
              state_q  <= (length == LEN_W'(1)) ? S_DRAIN : S_READ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (credit_ok) begin
            cs_q     <= 1'b1;
            addr_q   <= next_q;
            next_q   <= wrap_inc(next_q);
            remain_q <= remain_q - LEN_W'(1);
            if (remain_q == LEN_W'(1)) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (beat_fire && last_beat) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_onchip_frame_reader.sv
// Scoreboard bench for onchip_frame_reader with a behavioural latency-1 RAM.
module tb_onchip_frame_reader;

  localparam int MEM_WORDS = 163840;
  localparam int DEPTH     = 4;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [17:0] base_addr;
  logic [17:0] length;
  logic        busy;
  logic        done;
  logic [17:0] mem_address;
  logic        mem_chipselect;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_ready;
  logic        src_sop;
  logic        src_eop;

  onchip_frame_reader #(
    .ADDR_W(18), .DATA_W(32), .LEN_W(18), .MEM_WORDS(MEM_WORDS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  logic [31:0] ram [0:MEM_WORDS-1];
  beat_t       exp_q[$];
  int unsigned exp_addr_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rnd_ready = 0;

  int cs_cnt, valid_cnt, acc_cnt, done_cnt, first_cs, last_cs, first_v, start_cyc;
  bit busy_seen;
  int issued = 0, accepted = 0, max_out = 0;
  bit hold_pend = 0;
  logic [33:0] hold_val;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM slave: registered read, data valid the cycle after chipselect.
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) mem_readdata <= ram[mem_address];
  end

  initial forever begin
    @(posedge clk);
    #1;
    src_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: read-address and beat scoreboards, outstanding-word tracking.
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      hold_pend = 0;
    end else begin
      if (done) done_cnt++;
      if (busy) busy_seen = 1;
      if (mem_chipselect) begin
        if (cs_cnt == 0) first_cs = cyc;
        last_cs = cyc;
        cs_cnt++;
        issued++;
        if (exp_addr_q.size() == 0) chk("extra_read", 1, 0);
        else chk("rd_addr", 64'(mem_address), 64'(exp_addr_q.pop_front()));
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (hold_pend) chk("hold_stable", {src_valid, src_data, src_sop, src_eop}, {1'b1, hold_val});
      hold_pend = src_valid && !src_ready;
      hold_val  = {src_data, src_sop, src_eop};
      if (src_valid) begin
        if (valid_cnt == 0) first_v = cyc;
        valid_cnt++;
      end
      if (src_valid && src_ready) begin
        beat_t e;
        accepted++;
        acc_cnt++;
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(src_data), 64'(e.d));
          chk("beat_sop", 64'(src_sop), 64'(e.sop));
          chk("beat_eop", 64'(src_eop), 64'(e.eop));
        end
      end
    end
  end

  task automatic clear_stats();
    cs_cnt = 0; valid_cnt = 0; acc_cnt = 0; done_cnt = 0;
    first_cs = 0; last_cs = 0; first_v = 0; busy_seen = 0;
  endtask

  task automatic push_exp(input int unsigned base, input int unsigned len);
    int unsigned a = base;
    for (int unsigned i = 0; i < len; i++) begin
      exp_addr_q.push_back(a);
      exp_q.push_back({ram[a], (i == 0), (i == len - 1)});
      a = (a == MEM_WORDS - 1) ? 0 : a + 1;
    end
  endtask

  task automatic kick(input int unsigned base, input int unsigned len);
    @(posedge clk);
    #1;
    base_addr = 18'(base);
    length    = 18'(len);
    start     = 1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic run_xfer(input int unsigned base, input int unsigned len,
                          input bit rnd, input bit repulse);
    bit got = 0;
    clear_stats();
    push_exp(base, len);
    rnd_ready = rnd;
    kick(base, len);
    if (repulse) begin
      repeat (3) @(posedge clk);
      #1;
      base_addr = 18'd100;
      length    = 18'd3;
      start     = 1;
      @(posedge clk);
      #1;
      start = 0;
    end
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt != 0) begin
        got = 1;
        chk("busy_at_done", 64'(busy), 0);
      end
    end
    if (!got) chk("done_timeout", 0, 1);
    repeat (4) @(negedge clk);
    #1;
    rnd_ready = 0;
    chk("done_count", 64'(done_cnt), 1);
    chk("beats_left", 64'(exp_q.size()), 0);
    chk("reads_left", 64'(exp_addr_q.size()), 0);
    chk("beats_taken", 64'(acc_cnt), 64'(len));
    chk("busy_after", 64'(busy), 0);
    chk("busy_seen", 64'(busy_seen), 64'(len != 0));
  endtask

  initial begin
    bit hit;
    for (int i = 0; i < MEM_WORDS; i++) ram[i] = (32'(i) * 32'h9E3779B1) ^ 32'hA5A50000;
    reset_n = 0; start = 0; base_addr = '0; length = '0; src_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_cs", 64'(mem_chipselect), 0);
    chk("rst_addr", 64'(mem_address), 0);
    chk("rst_valid", 64'(src_valid), 0);
    chk("rst_sop_eop", {src_sop, src_eop}, 0);
    chk("const_be_clken", {mem_byteenable, mem_clken}, 5'h1F);
    @(negedge clk);
    reset_n = 1;

    // T1: sequential read, full throughput, latency check
    run_xfer(0, 8, 0, 0);
    chk("cs_latency", 64'(first_cs - start_cyc), 1);
    chk("valid_latency", 64'(first_v - start_cyc), 2);
    chk("cs_back_to_back", 64'(last_cs - first_cs), 7);

    // T2: random backpressure
    run_xfer(1000, 16, 1, 0);
    chk("max_outstanding_ok", 64'(max_out <= DEPTH), 1);

    // T3: address wrap at end of RAM
    run_xfer(163838, 4, 0, 0);

    // T4: single beat, then zero length
    run_xfer(77, 1, 1, 0);
    run_xfer(500, 0, 0, 0);
    chk("len0_no_cs", 64'(cs_cnt), 0);
    chk("len0_no_valid", 64'(valid_cnt), 0);

    // T5: start re-pulsed while busy is ignored
    run_xfer(2000, 8, 0, 1);

    // T6: reset mid-transfer, then a clean transfer
    clear_stats();
    push_exp(50, 16);
    rnd_ready = 1;
    kick(50, 16);
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (acc_cnt >= 3) hit = 1;
    end
    if (!hit) chk("t6_beats_timeout", 0, 1);
    reset_n = 0;
    #1;
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_done", 64'(done), 0);
    chk("midrst_cs", 64'(mem_chipselect), 0);
    chk("midrst_addr", 64'(mem_address), 0);
    chk("midrst_valid", 64'(src_valid), 0);
    chk("midrst_sop_eop", {src_sop, src_eop}, 0);
    rnd_ready = 0;
    exp_q.delete();
    exp_addr_q.delete();
    issued = 0;
    accepted = 0;
    repeat (2) @(negedge clk);
    reset_n = 1;
    run_xfer(0, 4, 0, 0);
    chk("post_rst_valid_latency", 64'(first_v - start_cyc), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
